// File: rtl/credit_link_arbiter_pkg.sv
// Shared types and helpers for the credit link arbiter: FSM state encoding
// and the credit counter width calculation.
package credit_link_pkg;

   typedef enum logic [1:0] {
      ST_RESET   = 2'd0,
      ST_WAIT_RX = 2'd1,
      ST_ACTIVE  = 2'd2
   } state_e;

   // Wide enough to hold every value from 0 up to and including maxCredits.
   function automatic int credit_width(input int maxCredits);
      return $clog2(maxCredits + 1);
   endfunction

endpackage

// File: rtl/credit_link_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after the pointer,
// wrapping modulo NUM_REQ, reported as a one-hot vector plus its index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               enable_i,
   input  logic [IW-1:0]      pointer_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [IW-1:0]      index_o,
   output logic               valid_o
);

   int cand;

   always_comb begin
      grant_o = '0;
      index_o = '0;
      valid_o = 1'b0;
      cand    = 0;
      // The pointer itself is visited last, so the previous winner has lowest priority.
      for (int off = 1; off <= NUM_REQ; off++) begin
         cand = (int'(pointer_i) + off) % NUM_REQ;
         if (enable_i && !valid_o && req_i[cand]) begin
            valid_o       = 1'b1;
            grant_o[cand] = 1'b1;
            index_o       = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/credit_link_arbiter.sv
// Sender side of a credit-based push link: round-robin sharing between local
// requesters, credit pool bookkeeping and bring-up around sender/receiver resets.
module credit_link_arbiter
   import credit_link_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_CREDITS = 4,
   localparam int CW = credit_width(MAX_CREDITS),
   localparam int IW = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [CW-1:0]                 credit_initial,
   input  logic [CW-1:0]                 credit_withhold,
   input  logic                          push_receiver_in_reset,
   input  logic                          push_credit,
   output logic                          push_sender_in_reset,
   output logic                          push_valid,
   output logic [DATA_WIDTH-1:0]         push_data,
   output logic [IW-1:0]                 grant_id,
   output logic [CW-1:0]                 credit_count,
   output logic                          credit_available,
   output logic                          credit_overflow
);

   localparam logic [CW-1:0] MaxCred = CW'(MAX_CREDITS);

   state_e                state_q;
   logic                  senderInReset_q;
   logic                  pushValid_q;
   logic [DATA_WIDTH-1:0] pushData_q;
   logic [IW-1:0]         grantId_q;
   logic [IW-1:0]         pointer_q;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;

   logic                  creditAvail;
   logic                  arbEnable;
   logic                  creditReturn;
   logic [NUM_REQ-1:0]    grantVec;
   logic [IW-1:0]         grantIdx;
   logic                  grantValid;
   logic [DATA_WIDTH-1:0] selData;
   logic [CW-1:0]         initLoad;

   // Grants need spendable credit and a receiver that is not dropping into reset this cycle.
   always_comb begin
      creditAvail  = count_q > credit_withhold;
      arbEnable    = (state_q == ST_ACTIVE) && creditAvail && !push_receiver_in_reset;
      creditReturn = push_credit && (state_q == ST_ACTIVE);
      initLoad     = (credit_initial > MaxCred) ? MaxCred : credit_initial;
      selData      = req_data[int'(grantIdx)*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i     (req_valid),
      .enable_i  (arbEnable),
      .pointer_i (pointer_q),
      .grant_o   (grantVec),
      .index_o   (grantIdx),
      .valid_o   (grantValid)
   );

   // A return into a full pool with nothing spent is dropped and flagged.
   always_comb begin
      count_d    = count_q + CW'(creditReturn) - CW'(grantValid);
      overflow_d = overflow_q;
      if (creditReturn && !grantValid && (count_q == MaxCred)) begin
         count_d    = count_q;
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_RESET;
         senderInReset_q <= 1'b1;
         pushValid_q     <= 1'b0;
         pushData_q      <= '0;
         grantId_q       <= '0;
         pointer_q       <= IW'(NUM_REQ - 1);
         count_q         <= '0;
         overflow_q      <= 1'b0;
      end else begin
         senderInReset_q <= 1'b0;
         pushValid_q     <= 1'b0;
         case (state_q)
            ST_RESET: begin
               state_q <= ST_WAIT_RX;
            end
            ST_WAIT_RX: begin
               if (!push_receiver_in_reset) begin
                  count_q <= initLoad;
                  state_q <= ST_ACTIVE;
               end
            end
            ST_ACTIVE: begin
               // Receiver reset forfeits all credit; the pointer survives so fairness carries over.
               if (push_receiver_in_reset) begin
                  count_q <= '0;
                  state_q <= ST_WAIT_RX;
               end else begin
                  count_q    <= count_d;
                  overflow_q <= overflow_d;
                  if (grantValid) begin
                     pushValid_q <= 1'b1;
                     pushData_q  <= selData;
                     grantId_q   <= grantIdx;
                     pointer_q   <= grantIdx;
                  end
               end
            end
            default: begin
               state_q <= ST_RESET;
            end
         endcase
      end
   end

   assign req_ready            = grantVec;
   assign push_sender_in_reset = senderInReset_q;
   assign push_valid           = pushValid_q;
   assign push_data            = pushData_q;
   assign grant_id             = grantId_q;
   assign credit_count         = count_q;
   assign credit_available     = creditAvail;
   assign credit_overflow      = overflow_q;

endmodule

// File: tb/tb_credit_link_arbiter.sv
// Directed bench for credit_link_arbiter: bring-up, round-robin drain, credit
// return, withholding, receiver reset with reload clamp, and sticky overflow.
module tb_credit_link_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [2:0]  credit_initial;
   logic [2:0]  credit_withhold;
   logic        push_receiver_in_reset;
   logic        push_credit;
   logic        push_sender_in_reset;
   logic        push_valid;
   logic [7:0]  push_data;
   logic [1:0]  grant_id;
   logic [2:0]  credit_count;
   logic        credit_available;
   logic        credit_overflow;

   int checkCount = 0;
   int passCount  = 0;

   credit_link_arbiter #(
      .NUM_REQ     (4),
      .DATA_WIDTH  (8),
      .MAX_CREDITS (4)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .req_valid              (req_valid),
      .req_data               (req_data),
      .req_ready              (req_ready),
      .credit_initial         (credit_initial),
      .credit_withhold        (credit_withhold),
      .push_receiver_in_reset (push_receiver_in_reset),
      .push_credit            (push_credit),
      .push_sender_in_reset   (push_sender_in_reset),
      .push_valid             (push_valid),
      .push_data              (push_data),
      .grant_id               (grant_id),
      .credit_count           (credit_count),
      .credit_available       (credit_available),
      .credit_overflow        (credit_overflow)
   );

   always #5 clk = ~clk;

   // Advance the given number of rising edges, then settle 1ns past the last one.
   task automatic applyStimulus(input int cycles);
      repeat (cycles) @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
   endtask

   initial begin
      rst                    = 1'b1;
      req_valid              = 4'hF;
      req_data               = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      credit_initial         = 3'd2;
      credit_withhold        = 3'd0;
      push_receiver_in_reset = 1'b0;
      push_credit            = 1'b0;

      // Reset state, with every requester asking
      applyStimulus(2);
      checkOutput("rst_sender_in_reset", push_sender_in_reset, 1);
      checkOutput("rst_push_valid", push_valid, 0);
      checkOutput("rst_push_data", push_data, 0);
      checkOutput("rst_grant_id", grant_id, 0);
      checkOutput("rst_count", credit_count, 0);
      checkOutput("rst_overflow", credit_overflow, 0);
      checkOutput("rst_req_ready", req_ready, 0);
      checkOutput("rst_available", credit_available, 0);

      // Bring-up: WAIT_RX after first low edge, credits loaded at the next one
      req_valid = 4'h0;
      rst       = 1'b0;
      applyStimulus(1);
      checkOutput("up_sender_in_reset", push_sender_in_reset, 0);
      checkOutput("up_count_wait", credit_count, 0);
      applyStimulus(1);
      checkOutput("up_count_loaded", credit_count, 2);
      checkOutput("up_available", credit_available, 1);

      // Fill to 4 by returning credits
      push_credit = 1'b1;
      applyStimulus(2);
      checkOutput("fill_count", credit_count, 4);
      push_credit = 1'b0;

      // Round-robin drain 0,1,2,3
      req_valid = 4'hF;
      applyStimulus(0);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("drain_ready_%0d", i), req_ready, 32'(1 << i));
         applyStimulus(1);
         checkOutput($sformatf("drain_valid_%0d", i), push_valid, 1);
         checkOutput($sformatf("drain_id_%0d", i), grant_id, i);
         checkOutput($sformatf("drain_data_%0d", i), push_data, 32'hA0 + 32'h11 * i);
         checkOutput($sformatf("drain_count_%0d", i), credit_count, 3 - i);
      end
      checkOutput("drain_ready_empty", req_ready, 0);
      checkOutput("drain_available_empty", credit_available, 0);
      applyStimulus(1);
      checkOutput("drain_valid_empty", push_valid, 0);

      // Simultaneous return and grant leaves the count unchanged
      req_valid   = 4'h0;
      push_credit = 1'b1;
      applyStimulus(1);
      checkOutput("simul_count_pre", credit_count, 1);
      req_valid = 4'b0100;
      applyStimulus(0);
      checkOutput("simul_ready", req_ready, 4'b0100);
      applyStimulus(1);
      checkOutput("simul_count", credit_count, 1);
      checkOutput("simul_valid", push_valid, 1);
      checkOutput("simul_id", grant_id, 2);
      checkOutput("simul_data", push_data, 8'hC2);

      // Withhold: count 2 with 2 withheld blocks, 1 withheld grants requester 3
      req_valid = 4'h0;
      applyStimulus(1);
      checkOutput("wh_count_pre", credit_count, 2);
      push_credit     = 1'b0;
      credit_withhold = 3'd2;
      req_valid       = 4'hF;
      applyStimulus(0);
      checkOutput("wh_available_blocked", credit_available, 0);
      checkOutput("wh_ready_blocked", req_ready, 0);
      applyStimulus(1);
      checkOutput("wh_count_held", credit_count, 2);
      checkOutput("wh_valid_blocked", push_valid, 0);
      credit_withhold = 3'd1;
      applyStimulus(0);
      checkOutput("wh_available_open", credit_available, 1);
      checkOutput("wh_ready_open", req_ready, 4'b1000);
      applyStimulus(1);
      checkOutput("wh_count_after", credit_count, 1);
      checkOutput("wh_id", grant_id, 3);
      checkOutput("wh_data", push_data, 8'hD3);
      req_valid       = 4'h0;
      credit_withhold = 3'd0;

      // Receiver reset mid-stream at count 3 with a push in flight
      push_credit = 1'b1;
      applyStimulus(3);
      checkOutput("rx_count_full", credit_count, 4);
      push_credit = 1'b0;
      req_valid   = 4'hF;
      applyStimulus(1);
      checkOutput("rx_count_pre", credit_count, 3);
      checkOutput("rx_valid_pre", push_valid, 1);
      checkOutput("rx_id_pre", grant_id, 0);
      push_receiver_in_reset = 1'b1;
      applyStimulus(0);
      checkOutput("rx_ready_blocked", req_ready, 0);
      applyStimulus(1);
      checkOutput("rx_count_zero", credit_count, 0);
      checkOutput("rx_valid_drop", push_valid, 0);
      push_credit = 1'b1;
      applyStimulus(1);
      checkOutput("rx_credit_ignored", credit_count, 0);
      checkOutput("rx_ready_wait", req_ready, 0);
      push_credit            = 1'b0;
      credit_initial         = 3'd7;
      push_receiver_in_reset = 1'b0;
      req_valid              = 4'h0;
      applyStimulus(1);
      checkOutput("rx_reload_clamped", credit_count, 4);
      req_valid = 4'hF;
      applyStimulus(0);
      checkOutput("rx_pointer_kept", req_ready, 4'b0010);
      req_valid = 4'h0;

      // Overflow: return into a full pool, sticky until rst
      push_credit = 1'b1;
      applyStimulus(1);
      checkOutput("ovf_count", credit_count, 4);
      checkOutput("ovf_flag", credit_overflow, 1);
      push_credit = 1'b0;
      applyStimulus(2);
      checkOutput("ovf_sticky", credit_overflow, 1);
      rst = 1'b1;
      applyStimulus(1);
      checkOutput("ovf_cleared", credit_overflow, 0);
      checkOutput("ovf_rst_sender", push_sender_in_reset, 1);
      checkOutput("ovf_rst_count", credit_count, 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/credit_link_arbiter.md
# credit_link_arbiter

Sender-side controller for a credit-based push link. Shares one push link between NUM_REQ local requesters using round-robin arbitration. Tracks the sender's credit pool: initial load, consumption per push, return via push_credit, and withholding. Sequences link bring-up around sender and receiver resets, and sits directly upstream of the credit receiver on the same link.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- DATA_WIDTH, 8, payload width
- MAX_CREDITS, 4, credit pool capacity; CW = $clog2(MAX_CREDITS+1) derived
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i payload at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  one-hot grant; combinational
- credit_initial  in  CW  credits loaded at link bring-up (clamped to MAX_CREDITS)
- credit_withhold  in  CW  credits reserved, not spendable
- push_receiver_in_reset  in  1  receiver reset indication
- push_credit  in  1  one credit returned by receiver
- push_sender_in_reset  out  1  registered; high while sender in reset
- push_valid  out  1  registered push strobe
- push_data  out  DATA_WIDTH  registered payload
- grant_id  out  $clog2(NUM_REQ)  requester index of the current push_data
- credit_count  out  CW  current pool
- credit_available  out  1  credit_count > credit_withhold
- credit_overflow  out  1  sticky; credit returned with the pool full

## Operation
- FSM states: RESET, WAIT_RX, ACTIVE.
- RESET is entered on any rst cycle. On rst low: → WAIT_RX.
- WAIT_RX: when push_receiver_in_reset = 0, load credit_count = min(credit_initial, MAX_CREDITS) and go → ACTIVE.
- ACTIVE: if push_receiver_in_reset = 1, set credit_count = 0, clear push_valid next cycle, and go → WAIT_RX. The round-robin pointer is kept.
- A grant is possible only in ACTIVE with credit_available = 1 and no receiver reset in the same cycle.
- Grant selection: the first valid requester searching from pointer+1 (mod NUM_REQ). The pointer is updated to the granted index only on a grant.
- On a grant:
  - req_ready[i] = 1 in the same cycle.
  - Next cycle: push_valid = 1, push_data = req_data[i], grant_id = i.
  - credit_count decrements on the grant cycle.
- Credit arithmetic: next = count + (push_credit & ACTIVE) − grant.
  - Return and grant in the same cycle: count unchanged.
  - Return with count = MAX_CREDITS and no grant: count saturates and credit_overflow is set until rst.
- push_credit is ignored outside ACTIVE.
- A grant never drives the count below zero, because availability requires count > withhold ≥ 0.

## Timing
- Reset values:
  - push_sender_in_reset = 1
  - push_valid = 0, push_data = 0, grant_id = 0
  - credit_count = 0, credit_overflow = 0
  - pointer = NUM_REQ−1, so requester 0 wins first
  - req_ready = 0, credit_available = 0
- push_sender_in_reset falls at the first edge with rst low.
- Bring-up: rst low at edge k → WAIT_RX. With receiver out of reset, the count is loaded at edge k+1 and the first grant is possible in cycle k+1.
- Grant-to-push latency is 1 cycle. Sustained throughput is 1 push per cycle while credits are available.
- credit_available and req_ready are combinational from registered count and pointer, plus req_valid and credit_withhold.

## Structure
- Package credit_link_pkg holds:
  - state enum (RESET, WAIT_RX, ACTIVE)
  - the CW width function
- Sub-module rr_arbiter (NUM_REQ): takes req, enable and pointer; returns one-hot grant and index.
- Top level holds the FSM, credit counter and output registers.

## Test plan
- Bring-up: credit_initial=2, rst 2 cycles then low, receiver not in reset → credit_count=2 one cycle after rst falls, push_sender_in_reset=0.
- Round-robin drain: count=4, all req_valid=1, distinct data → grant_id sequence 0,1,2,3 on consecutive push_valid cycles; count reaches 0; further req_ready=0.
- Simultaneous return: count=1, push_credit=1 with a grant → count stays 1, push_valid next cycle.
- Withhold: count=2, credit_withhold=2 → no grant, credit_available=0. Withhold set to 1 → grant in that cycle, count becomes 1.
- Receiver reset mid-stream: ACTIVE, count=3, push_receiver_in_reset=1 → count=0, push_valid=0 next cycle, WAIT_RX. Deassert → count reloads credit_initial one cycle later.
- Overflow: count=MAX_CREDITS=4, push_credit=1, no req → count=4, credit_overflow=1, sticky until rst.
